// File: rtl/meduram_read_mux_if.sv
// Read-side bus of the memory-map read mux: per-agent requests, bank data
// array in, selected data, collision flags and counters out.
interface meduram_read_mux_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int NB_WRAGENT      = 2,
  parameter int NB_RDAGENT      = 2,
  parameter int WRITE_COLLISION = 1,
  parameter int SELECT_WIDTH    = (NB_WRAGENT == 1 ? 1 : $clog2(NB_WRAGENT)) + WRITE_COLLISION,
  parameter int CNT_WIDTH       = 16
);

  logic [NB_RDAGENT-1:0]                       rden;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0]          bank_select;
  logic [NB_RDAGENT*NB_WRAGENT*DATA_WIDTH-1:0] bank_rddata;
  logic [NB_RDAGENT-1:0]                       cnt_clear;
  logic [NB_RDAGENT-1:0]                       rdvalid;
  logic [NB_RDAGENT*DATA_WIDTH-1:0]            rddata;
  logic [NB_RDAGENT-1:0]                       rdcollision;
  logic [NB_RDAGENT*CNT_WIDTH-1:0]             collision_cnt;

  modport master (
    output rden, bank_select, bank_rddata, cnt_clear,
    input  rdvalid, rddata, rdcollision, collision_cnt
  );

  modport slave (
    input  rden, bank_select, bank_rddata, cnt_clear,
    output rdvalid, rddata, rdcollision, collision_cnt
  );

endinterface

// File: rtl/meduram_read_mux.sv
// Read mux for the banked memory map: delays each agent's bank selector through
// the RAM read latency, selects the winning bank and counts collision reads.
// Optional macro MEDURAM_RDMUX_OUTREG_EN adds a second output register stage.
module meduram_read_mux #(
  parameter int DATA_WIDTH      = 32,
  parameter int NB_WRAGENT      = 2,
  parameter int NB_RDAGENT      = 2,
  parameter int WRITE_COLLISION = 1,
  parameter int SELECT_WIDTH    = (NB_WRAGENT == 1 ? 1 : $clog2(NB_WRAGENT)) + WRITE_COLLISION,
  parameter int RD_LATENCY      = 1,
  parameter int CNT_WIDTH       = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  meduram_read_mux_if.slave  bus
);

  localparam int IDX_W = SELECT_WIDTH - WRITE_COLLISION;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  for (genvar r = 0; r < NB_RDAGENT; r++) begin : g_agent

    logic [RD_LATENCY-1:0]   vld_pipe;
    logic [SELECT_WIDTH-1:0] sel_pipe [RD_LATENCY];
    logic [SELECT_WIDTH-1:0] sel_last;
    logic [IDX_W-1:0]        idx;
    logic                    sel_coll;

    logic [DATA_WIDTH-1:0]   mux_data;
    logic                    mux_hit;
    logic                    mux_coll;

    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   s1_data;
    logic                    s1_coll;

    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_coll;

    logic [CNT_WIDTH-1:0]    cnt;

    // Valid bits are reset so in-flight reads die with reset; selectors need not be.
    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[0] <= bus.rden[r];
        for (int i = 1; i < RD_LATENCY; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
        end
      end
    end

    always_ff @(posedge aclk) begin
      sel_pipe[0] <= bus.bank_select[r*SELECT_WIDTH +: SELECT_WIDTH];
      for (int i = 1; i < RD_LATENCY; i++) begin
        sel_pipe[i] <= sel_pipe[i-1];
      end
    end

    assign sel_last = sel_pipe[RD_LATENCY-1];
    assign idx      = sel_last[IDX_W-1:0];

    if (WRITE_COLLISION != 0) begin : g_coll
      assign sel_coll = sel_last[SELECT_WIDTH-1];
    end else begin : g_nocoll
      assign sel_coll = 1'b0;
    end

    if (NB_WRAGENT == 1) begin : g_single
      always_comb begin
        mux_data = bus.bank_rddata[r*DATA_WIDTH +: DATA_WIDTH];
        mux_hit  = 1'b1;
      end
    end else begin : g_multi
      // An index beyond the last bank returns zero and is reported as a collision.
      always_comb begin
        mux_data = '0;
        mux_hit  = 1'b0;
        for (int w = 0; w < NB_WRAGENT; w++) begin
          if (idx == IDX_W'(w)) begin
            mux_data = bus.bank_rddata[(r*NB_WRAGENT+w)*DATA_WIDTH +: DATA_WIDTH];
            mux_hit  = 1'b1;
          end
        end
      end
    end

    assign mux_coll = sel_coll | ~mux_hit;

    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
        s1_coll  <= 1'b0;
      end else begin
        s1_valid <= vld_pipe[RD_LATENCY-1];
        if (vld_pipe[RD_LATENCY-1]) begin
          s1_data <= mux_data;
          s1_coll <= mux_coll;
        end else begin
          s1_coll <= 1'b0;
        end
      end
    end

`ifdef MEDURAM_RDMUX_OUTREG_EN
    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_coll  <= 1'b0;
      end else begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= s1_data;
          out_coll <= s1_coll;
        end else begin
          out_coll <= 1'b0;
        end
      end
    end
`else
    assign out_valid = s1_valid;
    assign out_data  = s1_data;
    assign out_coll  = s1_coll;
`endif

    // Clear has priority over a coincident increment.
    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        cnt <= '0;
      end else if (bus.cnt_clear[r]) begin
        cnt <= '0;
      end else if (out_valid && out_coll && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end

    assign bus.rdvalid[r]                                = out_valid;
    assign bus.rddata[r*DATA_WIDTH +: DATA_WIDTH]        = out_data;
    assign bus.rdcollision[r]                            = out_coll;
    assign bus.collision_cnt[r*CNT_WIDTH +: CNT_WIDTH]   = cnt;

  end

endmodule

// File: tb/tb_meduram_read_mux.sv
// Directed bench for meduram_read_mux: latency, ordering, collision flag,
// counter saturation/clear and reset flush on three latency configurations.
module tb_meduram_read_mux;

`ifdef MEDURAM_RDMUX_OUTREG_EN
  localparam int E = 1;
`else
  localparam int E = 0;
`endif

  logic aclk;
  logic aresetn;
  int   tests_run;
  int   tests_failed;

  meduram_read_mux_if #(.DATA_WIDTH(32), .NB_WRAGENT(2), .NB_RDAGENT(2), .WRITE_COLLISION(1), .CNT_WIDTH(16)) bus_l1 ();
  meduram_read_mux_if #(.DATA_WIDTH(32), .NB_WRAGENT(2), .NB_RDAGENT(2), .WRITE_COLLISION(1), .CNT_WIDTH(16)) bus_l2 ();
  meduram_read_mux_if #(.DATA_WIDTH(32), .NB_WRAGENT(2), .NB_RDAGENT(2), .WRITE_COLLISION(1), .CNT_WIDTH(16)) bus_l3 ();

  meduram_read_mux #(.RD_LATENCY(1)) u_l1 (.aclk(aclk), .aresetn(aresetn), .bus(bus_l1));
  meduram_read_mux #(.RD_LATENCY(2)) u_l2 (.aclk(aclk), .aresetn(aresetn), .bus(bus_l2));
  meduram_read_mux #(.RD_LATENCY(3)) u_l3 (.aclk(aclk), .aresetn(aresetn), .bus(bus_l3));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    aresetn = 1'b0;
    bus_l1.rden = '0; bus_l1.bank_select = '0; bus_l1.cnt_clear = '0;
    bus_l2.rden = '0; bus_l2.bank_select = '0; bus_l2.cnt_clear = '0;
    bus_l3.rden = '0; bus_l3.bank_select = '0; bus_l3.cnt_clear = '0;
    // agent0: bank0 0x11111111, bank1 0xDEADBEEF; agent1: bank0 0x22222222, bank1 0x33333333
    bus_l1.bank_rddata = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
    bus_l2.bank_rddata = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
    bus_l3.bank_rddata = '0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();

    check("rst_rdvalid_l1", 64'(bus_l1.rdvalid), 64'h0);
    check("rst_rddata_l1",  64'(bus_l1.rddata), 64'h0);
    check("rst_rdcoll_l1",  64'(bus_l1.rdcollision), 64'h0);
    check("rst_cnt_l1",     64'(bus_l1.collision_cnt), 64'h0);
    check("rst_rdvalid_l3", 64'(bus_l3.rdvalid), 64'h0);

    // Single read, agent0, bank1, L=1: valid only at T+2(+E)
    for (int k = 0; k < 6; k++) begin
      bus_l1.rden[0]           = (k == 0);
      bus_l1.bank_select[1:0]  = 2'b01;
      if (k == 2 + E) begin
        check("t1_valid", 64'(bus_l1.rdvalid[0]), 64'h1);
        check("t1_data",  64'(bus_l1.rddata[31:0]), 64'hDEADBEEF);
        check("t1_coll",  64'(bus_l1.rdcollision[0]), 64'h0);
      end else begin
        check("t1_idle_valid", 64'(bus_l1.rdvalid[0]), 64'h0);
      end
      check("t1_agent1_idle", 64'(bus_l1.rdvalid[1]), 64'h0);
      tick();
    end
    check("t1_data_hold", 64'(bus_l1.rddata[31:0]), 64'hDEADBEEF);

    // Four back-to-back reads on agent1, L=3, selects 0,1,0,1
    for (int k = 0; k < 10; k++) begin
      int i;
      bus_l3.rden[1]          = (k < 4);
      bus_l3.bank_select[3:2] = {1'b0, 1'(k % 2)};
      i = k - 3;
      if (i >= 0 && i < 4) begin
        if (i % 2 == 0) begin
          bus_l3.bank_rddata[64 +: 32] = 32'hA0 + 32'(i);
          bus_l3.bank_rddata[96 +: 32] = 32'hEE;
        end else begin
          bus_l3.bank_rddata[64 +: 32] = 32'hEE;
          bus_l3.bank_rddata[96 +: 32] = 32'hA0 + 32'(i);
        end
      end else begin
        bus_l3.bank_rddata[64 +: 64] = {32'h55, 32'h55};
      end
      if (k >= 4 + E && k <= 7 + E) begin
        check("t2_valid", 64'(bus_l3.rdvalid[1]), 64'h1);
        check("t2_data",  64'(bus_l3.rddata[63:32]), 64'hA0 + 64'(k - 4 - E));
        check("t2_coll",  64'(bus_l3.rdcollision[1]), 64'h0);
      end else begin
        check("t2_idle_valid", 64'(bus_l3.rdvalid[1]), 64'h0);
      end
      tick();
    end

    // Collision read: select 0b10 -> bank0 data, flag, counter 1
    for (int k = 0; k < 6; k++) begin
      bus_l1.rden[0]          = (k == 0);
      bus_l1.bank_select[1:0] = 2'b10;
      if (k == 2 + E) begin
        check("t3_valid", 64'(bus_l1.rdvalid[0]), 64'h1);
        check("t3_data",  64'(bus_l1.rddata[31:0]), 64'h11111111);
        check("t3_coll",  64'(bus_l1.rdcollision[0]), 64'h1);
        check("t3_cnt_before", 64'(bus_l1.collision_cnt[15:0]), 64'h0);
      end
      if (k == 3 + E) begin
        check("t3_coll_drop", 64'(bus_l1.rdcollision[0]), 64'h0);
        check("t3_cnt_one",   64'(bus_l1.collision_cnt[15:0]), 64'h1);
      end
      tick();
    end

    bus_l1.rden[0] = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    bus_l1.rden[0] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("t3_cnt_ten", 64'(bus_l1.collision_cnt[15:0]), 64'd10);

    bus_l1.rden[0] = 1'b1;
    for (int k = 0; k < 32'hFFFF + 5; k++) tick();
    bus_l1.rden[0] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("t3_cnt_sat", 64'(bus_l1.collision_cnt[15:0]), 64'hFFFF);
    check("t3_cnt_agent1", 64'(bus_l1.collision_cnt[31:16]), 64'h0);

    // Clear coincident with a collision rdvalid: clear wins
    for (int k = 0; k < 5; k++) begin
      bus_l1.rden[0]          = (k == 0);
      bus_l1.bank_select[1:0] = 2'b10;
      bus_l1.cnt_clear[0]     = (k == 2 + E);
      if (k == 2 + E) begin
        check("t4_valid_coll", 64'({bus_l1.rdvalid[0], bus_l1.rdcollision[0]}), 64'h3);
        check("t4_cnt_pre",    64'(bus_l1.collision_cnt[15:0]), 64'hFFFF);
      end
      if (k > 2 + E) check("t4_cnt_cleared", 64'(bus_l1.collision_cnt[15:0]), 64'h0);
      tick();
    end
    bus_l1.cnt_clear[0] = 1'b0;

    for (int k = 0; k < 5; k++) begin
      bus_l1.rden[0] = (k == 0);
      tick();
    end
    check("t4_cnt_after", 64'(bus_l1.collision_cnt[15:0]), 64'h1);

    // Reset with two reads in flight on L=2
    bus_l2.bank_select[1:0] = 2'b01;
    bus_l2.rden[0] = 1'b1;
    tick();
    bus_l2.bank_select[1:0] = 2'b00;
    tick();
    bus_l2.rden[0] = 1'b0;
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("t5_no_valid", 64'(bus_l2.rdvalid), 64'h0);
      check("t5_rddata",   64'(bus_l2.rddata), 64'h0);
      tick();
    end
    check("t5_cnt_l1", 64'(bus_l1.collision_cnt), 64'h0);
    check("t5_cnt_l2", 64'(bus_l2.collision_cnt), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/meduram_read_mux.md
Name: meduram_read_mux

Overview:
- Read-side companion of the memory-map accounter.
- Per read agent, takes the bank selector the accounter produces at read-request time and carries it through the RAM read latency.
- Picks the read data of the write-agent bank that last updated the row, and returns it with a valid strobe.
- Flags and counts write-collision reads. Sits between the NB_WRAGENT x NB_RDAGENT RAM bank array and the read agents.

Parameters:
- DATA_WIDTH, 32, read data width per bank.
- NB_WRAGENT, 2, number of write agents (banks per read agent).
- NB_RDAGENT, 2, number of read agents.
- WRITE_COLLISION, 1, selector carries a collision flag in its MSB when 1.
- SELECT_WIDTH, (NB_WRAGENT==1 ? 1 : $clog2(NB_WRAGENT)) + WRITE_COLLISION, bank selector width.
- RD_LATENCY, 1, RAM read latency in cycles, legal range 1..8.
- CNT_WIDTH, 16, collision counter width per read agent.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset. Synchronous, active-low.
- rden  in  NB_RDAGENT  read request per agent, sampled every cycle.
- bank_select  in  NB_RDAGENT*SELECT_WIDTH  accounter selector, valid in the same cycle as rden.
- bank_rddata  in  NB_RDAGENT*NB_WRAGENT*DATA_WIDTH  bank data. Slice for read agent r, bank w starts at bit (r*NB_WRAGENT+w)*DATA_WIDTH.
- cnt_clear  in  NB_RDAGENT  clears that agent's collision counter.
- rdvalid  out  NB_RDAGENT  read data valid.
- rddata  out  NB_RDAGENT*DATA_WIDTH  selected read data.
- rdcollision  out  NB_RDAGENT  the returned word was written by colliding writers.
- collision_cnt  out  NB_RDAGENT*CNT_WIDTH  saturating collision-read count per agent.

Behaviour:
- Reset (aresetn=0 at a rising edge):
  - All pipeline valid bits, rdvalid, rdcollision and collision_cnt go to 0; rddata goes to 0.
  - Selector pipeline contents are don't-care but valid bits are cleared.
  - Reads in flight when reset is asserted are discarded; nothing is returned for them after reset releases.
- Per read agent, independent instance of the same logic. There is no backpressure.
- Cycle T, rden[r]=1: capture bank_select[r] into stage 1 of a RD_LATENCY-deep shift register along with valid=1.
- A new request may be accepted every cycle; up to RD_LATENCY reads are in flight per agent.
- Selector decode:
  - index = selector[SELECT_WIDTH-1-WRITE_COLLISION:0].
  - coll = selector[SELECT_WIDTH-1] when WRITE_COLLISION=1, else 0.
- Cycle T+RD_LATENCY: the banks present data for the request; the final stage selector muxes bank_rddata[r][index].
- The mux result is registered, so rdvalid[r], rddata[r] and rdcollision[r] are valid during cycle T+RD_LATENCY+1 for exactly one cycle per request.
- index >= NB_WRAGENT (non-power-of-2 bank count): rddata = 0, rdcollision = 1, counted as a collision.
- NB_WRAGENT==1: index is ignored and bank 0 is always selected.
- When rdvalid=0, rddata holds its last value and rdcollision=0.
- Collision counter increments by 1 in the cycle rdvalid & rdcollision is asserted, and saturates at 2^CNT_WIDTH-1 with no wrap.
- cnt_clear=1 forces the counter to 0 on the next edge. If cnt_clear and an increment coincide, the result is 0; clear wins.
- Back-to-back rden with differing selectors must return data from each one's own bank, in order; no selector bleed between requests.

Optional Feature:
- Macro MEDURAM_RDMUX_OUTREG_EN.
- Defined: a second output register stage is added to rdvalid/rddata/rdcollision, so latency becomes RD_LATENCY+2. The collision counter updates from the second stage.
- Undefined: latency is RD_LATENCY+1, as described above.
- Reset and clear behaviour is identical in both builds.

Test Plan:
- Reset, then RD_LATENCY=1, NB_WRAGENT=2, rden[0]=1 at T with select=0b01 and bank1 data=0xDEADBEEF at T+1 -> rdvalid[0]=1, rddata[0]=0xDEADBEEF, rdcollision=0 at T+2, then rdvalid=0 at T+3.
- RD_LATENCY=3, four back-to-back reads on agent 1 with selects 0,1,0,1 and bank data 0xA0..0xA3 -> four consecutive valid cycles returning 0xA0,0xA1,0xA2,0xA3 starting at T+4.
- Select=0b10 (collision, bank 0) -> rdcollision=1 with bank0 data, collision_cnt increments to 1. Repeat 0xFFFF+5 times with CNT_WIDTH=16 -> counter stays at 0xFFFF.
- cnt_clear=1 in the same cycle as a collision rdvalid -> collision_cnt=0 next cycle.
- Two reads in flight with RD_LATENCY=2 and aresetn=0 for one cycle -> no rdvalid after release; counters=0.
- Build with MEDURAM_RDMUX_OUTREG_EN, repeat test 1 -> data appears at T+3.
